// File: rtl/timer_display_scan_if.sv
// Bundle between the countdown timer and the seven-segment scan driver:
// the time fields and blink request flow in, the anode/segment/dp drive
// flows out toward the board pins.
interface timer_display_scan_if;
  logic [4:0] hour_in;
  logic [5:0] min_in;
  logic [5:0] sec_in;
  logic       blink_en;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  // Timer side: supplies the time and blink request, observes the display.
  modport master (
    output hour_in, min_in, sec_in, blink_en,
    input  an, seg, dp
  );

  // Display driver side.
  modport slave (
    input  hour_in, min_in, sec_in, blink_en,
    output an, seg, dp
  );
endinterface

// File: rtl/timer_display_scan.sv
// Eight-digit multiplexed seven-segment driver showing HH.MM.SS on digits
// 5..0 (digits 7..6 dark). The slow timer fields are snapshotted once per
// scan frame so a frame never mixes old and new values. Provides leading
// hour-zero blanking, dashes for out-of-range fields and a whole-display blink.
module timer_display_scan #(
  parameter int REFRESH_DIV  = 100000,  // clk cycles each digit is lit, >= 2
  parameter int BLINK_FRAMES = 64       // scan frames per blink half-period, >= 1
) (
  input logic             clk,
  input logic             resetn,
  timer_display_scan_if.slave bus
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST   = FW'(BLINK_FRAMES - 1);
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Split a value 0..63 into {tens, ones}; only meaningful for valid fields.
  function automatic logic [7:0] split_bcd(input logic [5:0] v);
    logic [3:0] t;
    t = 4'd0;
    for (int i = 1; i <= 6; i++) begin
      if (v >= 6'(i * 10)) t = 4'(i);
    end
    return {t, 4'(v - 6'(t) * 6'd10)};
  endfunction

  // Active-low gfedcba pattern for a decimal digit.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  logic [RW-1:0] refresh_q;
  logic [2:0]    digit_q;
  logic [FW-1:0] frame_q;
  logic          blink_q;
  logic          load_pending_q;
  logic [4:0]    hour_q;
  logic [5:0]    min_q;
  logic [5:0]    sec_q;
  logic [7:0]    an_q,  an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q,  dp_d;

  logic          refresh_tc;
  logic          frame_end;
  logic [4:0]    src_hour;
  logic [5:0]    src_min;
  logic [5:0]    src_sec;
  logic          hour_ok, min_ok, sec_ok;
  logic [7:0]    hour_bcd, min_bcd, sec_bcd;
  logic [3:0]    nib;
  logic          fld_ok;
  logic          blank;

  assign refresh_tc = (refresh_q == REFRESH_LAST);
  assign frame_end  = refresh_tc && (digit_q == 3'd5);

  // Right after reset the snapshot is still empty, so the very first digit
  // is rendered straight from the inputs being captured on that same edge.
  assign src_hour = load_pending_q ? bus.hour_in : hour_q;
  assign src_min  = load_pending_q ? bus.min_in  : min_q;
  assign src_sec  = load_pending_q ? bus.sec_in  : sec_q;

  assign hour_ok  = (src_hour < 5'd24);
  assign min_ok   = (src_min  < 6'd60);
  assign sec_ok   = (src_sec  < 6'd60);
  assign hour_bcd = split_bcd({1'b0, src_hour});
  assign min_bcd  = split_bcd(src_min);
  assign sec_bcd  = split_bcd(src_sec);

  // Decode the pattern for the digit currently being scanned.
  always_comb begin
    nib    = 4'd0;
    fld_ok = 1'b0;
    blank  = 1'b0;
    an_d   = 8'hFF;
    seg_d  = SEG_BLANK;
    dp_d   = 1'b1;
    case (digit_q)
      3'd0: begin nib = sec_bcd[3:0];  fld_ok = sec_ok;  end
      3'd1: begin nib = sec_bcd[7:4];  fld_ok = sec_ok;  end
      3'd2: begin nib = min_bcd[3:0];  fld_ok = min_ok;  end
      3'd3: begin nib = min_bcd[7:4];  fld_ok = min_ok;  end
      3'd4: begin nib = hour_bcd[3:0]; fld_ok = hour_ok; end
      3'd5: begin
        nib    = hour_bcd[7:4];
        fld_ok = hour_ok;
        blank  = hour_ok && (src_hour < 5'd10);
      end
      default: ;
    endcase
    if ((digit_q <= 3'd5) && !blank) begin
      an_d  = ~(8'd1 << digit_q);
      seg_d = fld_ok ? seg_code(nib) : SEG_DASH;
    end
    dp_d = !((digit_q == 3'd2) || (digit_q == 3'd4));
    if (blink_q && bus.blink_en) begin
      an_d  = 8'hFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  // Digit scan timing and blink phase generation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      refresh_q <= '0;
      digit_q   <= 3'd0;
      frame_q   <= '0;
      blink_q   <= 1'b0;
    end else begin
      if (refresh_tc) begin
        refresh_q <= '0;
        digit_q   <= (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
      end else begin
        refresh_q <= refresh_q + RW'(1);
      end
      if (!bus.blink_en) begin
        frame_q <= '0;
        blink_q <= 1'b0;
      end else if (frame_end) begin
        if (frame_q == FRAME_LAST) begin
          frame_q <= '0;
          blink_q <= ~blink_q;
        end else begin
          frame_q <= frame_q + FW'(1);
        end
      end
    end
  end

  // Capture the timer fields once after reset and then once per frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      load_pending_q <= 1'b1;
      hour_q         <= '0;
      min_q          <= '0;
      sec_q          <= '0;
    end else begin
      load_pending_q <= 1'b0;
      if (load_pending_q || frame_end) begin
        hour_q <= bus.hour_in;
        min_q  <= bus.min_in;
        sec_q  <= bus.sec_in;
      end
    end
  end

  // Register the pin drive; dark while in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      an_q  <= 8'hFF;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_timer_display_scan.sv
// Bench for timer_display_scan: a reference model predicts the display for
// every clock edge from the scan rules, a monitor compares each cycle.
module tb_timer_display_scan;
  localparam int DIV   = 4;
  localparam int BF    = 2;
  localparam int FRAME = 6 * DIV;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  timer_display_scan_if bus_if ();

  timer_display_scan #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  localparam disp_t DARK = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};

  disp_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Model state: edge count since reset release, frozen snapshot, blink.
  int    m_k = 0;
  int    m_h = 0, m_m = 0, m_s = 0;
  int    m_frames = 0;
  bit    m_phase = 1'b0;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // What the panel should show for digit d of time h:mi:s.
  function automatic disp_t render(input int h, input int mi, input int s,
                                   input int d, input bit dark);
    disp_t e;
    int    val[6];
    bit    ok[6];
    e = DARK;
    if (dark) return e;
    val[0] = s % 10;  val[1] = s / 10;
    val[2] = mi % 10; val[3] = mi / 10;
    val[4] = h % 10;  val[5] = h / 10;
    ok[0] = (s < 60);  ok[1] = (s < 60);
    ok[2] = (mi < 60); ok[3] = (mi < 60);
    ok[4] = (h < 24);  ok[5] = (h < 24);
    e.dp = (d == 2 || d == 4) ? 1'b0 : 1'b1;
    if (d == 5 && h < 10) return e;
    e.an  = 8'hFF & ~(8'd1 << d);
    e.seg = ok[d] ? seg_of(val[d]) : 7'b0111111;
    return e;
  endfunction

  function automatic disp_t cur();
    return {bus_if.an, bus_if.seg, bus_if.dp};
  endfunction

  task automatic check(input string name, input disp_t got, input disp_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0t: got an=%h seg=%b dp=%b, required an=%h seg=%b dp=%b",
                  name, $time, got.an, got.seg, got.dp, want.an, want.seg, want.dp);
  endtask

  // Reference model: one expected display per clock edge.
  initial begin
    int d;
    bit dark;
    forever begin
      @(posedge clk);
      if (resetn !== 1'b1) begin
        m_k = 0; m_h = 0; m_m = 0; m_s = 0;
        m_frames = 0; m_phase = 1'b0;
        exp_q.push_back(DARK);
      end else begin
        m_k++;
        if (m_k == 1) begin
          m_h = int'(bus_if.hour_in); m_m = int'(bus_if.min_in); m_s = int'(bus_if.sec_in);
        end
        d    = ((m_k - 1) / DIV) % 6;
        dark = m_phase && bus_if.blink_en;
        exp_q.push_back(render(m_h, m_m, m_s, d, dark));
        if (m_k % FRAME == 0) begin
          m_h = int'(bus_if.hour_in); m_m = int'(bus_if.min_in); m_s = int'(bus_if.sec_in);
        end
        if (!bus_if.blink_en) begin
          m_frames = 0;
          m_phase  = 1'b0;
        end else if (m_k % FRAME == 0) begin
          m_frames++;
          if (m_frames == BF) begin
            m_frames = 0;
            m_phase  = !m_phase;
          end
        end
      end
    end
  end

  // Monitor: compare the registered display once per cycle.
  initial begin
    disp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("scan", cur(), e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int mi, input int s);
    bus_if.hour_in = 5'(h);
    bus_if.min_in  = 6'(mi);
    bus_if.sec_in  = 6'(s);
  endtask

  initial begin
    set_time(12, 34, 56);
    bus_if.blink_en = 1'b0;
    step(3);
    $display("reset held: an=%h seg=%b dp=%b", bus_if.an, bus_if.seg, bus_if.dp);
    check("reset_hold", cur(), DARK);

    resetn = 1'b1;
    $display("release with 12:34:56");
    @(negedge clk);
    check("digit0_first", cur(), '{an: 8'hFE, seg: 7'b0000010, dp: 1'b1});
    repeat (8) @(negedge clk);
    check("digit2_sep", cur(), '{an: 8'hFB, seg: 7'b0011001, dp: 1'b0});
    step(40);

    $display("hour=5 leading blank");
    set_time(5, 34, 56);
    step(60);

    $display("sec 56->55 mid frame");
    set_time(12, 34, 56);
    step(30);
    set_time(12, 34, 55);
    step(50);

    $display("min=60 dashes");
    set_time(12, 60, 55);
    step(50);
    set_time(12, 34, 56);

    $display("blink enabled");
    bus_if.blink_en = 1'b1;
    step(6 * FRAME);
    for (int i = 0; i < 200 && !m_phase; i++) step(1);
    n_checks++;
    if (m_phase) n_pass++;
    else $display("FAIL blink_wait: got phase=0, required phase=1 within 200 cycles");
    step(5);
    $display("blink dropped during dark frame");
    bus_if.blink_en = 1'b0;
    step(30);

    $display("reset mid-scan");
    step(13);
    resetn = 1'b0;
    #1;
    check("async_reset", cur(), DARK);
    step(2);
    set_time(23, 59, 59);
    resetn = 1'b1;
    step(40);

    $display("randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19, 0) == 0) begin
        if ($urandom_range(3, 0) == 0)
          set_time(int'($urandom_range(31, 0)), int'($urandom_range(63, 0)),
                   int'($urandom_range(63, 0)));
        else
          set_time(int'($urandom_range(23, 0)), int'($urandom_range(59, 0)),
                   int'($urandom_range(59, 0)));
      end
      if ($urandom_range(59, 0) == 0) bus_if.blink_en = ~bus_if.blink_en;
      if ($urandom_range(399, 0) == 0) begin
        resetn = 1'b0;
        #1;
        check("rand_reset", cur(), DARK);
        step(int'($urandom_range(3, 1)));
        resetn = 1'b1;
      end
      step(1);
    end

    step(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
